// File: rtl/psu_rail_sequencer_if.sv
// Control/status bundle between the rail sequencer and its supervisor and PID stages.
interface psu_rail_sequencer_if;
  logic       start;
  logic       stop;
  logic       clr_fault;
  logic [4:0] pg;
  logic [4:0] act_ctl;
  logic [2:0] state;
  logic       all_good;
  logic       fault;
  logic [2:0] fault_rail;

  modport master (
    output start, stop, clr_fault, pg,
    input  act_ctl, state, all_good, fault, fault_rail
  );

  modport slave (
    input  start, stop, clr_fault, pg,
    output act_ctl, state, all_good, fault, fault_rail
  );
endinterface

// File: rtl/psu_rail_sequencer.sv
// Five-rail power sequencer: ordered bring-up with power-good wait and dwell, reverse shutdown,
// instant drop on fault. Define SEQ_AUTO_RETRY_EN to enable timed automatic restart from FAULT.
module psu_rail_sequencer #(
  parameter int unsigned STEP_DELAY  = 50000,
  parameter int unsigned PG_TIMEOUT  = 1000000,
  parameter int unsigned RETRY_DELAY = 5000000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input logic                  clk,
  input logic                  rst,
  psu_rail_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StUp    = 3'd1,
    StDwell = 3'd2,
    StOn    = 3'd3,
    StDown  = 3'd4,
    StFault = 3'd5
  } state_e;

  if ((STEP_DELAY < 1) || (PG_TIMEOUT < 2) || (RETRY_DELAY < 1) || (MAX_RETRIES > 3))
  begin : g_param_check
    $error("psu_rail_sequencer: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] timer_q;
  logic        timer_clr;
  logic [4:0]  act_q, act_d;
  logic [2:0]  rail_q, rail_d;
  logic        good_q, fault_q;

  logic [4:0]  watch;
  logic [4:0]  lost;
  logic        lost_any;
  logic [2:0]  lost_idx;
  logic        pg_cur;
  logic        at_step, at_timeout;

  assign at_step    = (32'(timer_q) == STEP_DELAY - 1);
  assign at_timeout = (32'(timer_q) == PG_TIMEOUT - 1);
  assign pg_cur     = bus.pg[idx_q];

`ifdef SEQ_AUTO_RETRY_EN
  logic [1:0] retries_q, retries_d;
  logic       at_retry;
  assign at_retry = (32'(timer_q) == RETRY_DELAY - 1);
`endif

  // Rails below the current one must stay good; in ON every rail is watched.
  always_comb begin
    watch    = (state_q == StOn) ? 5'h1f : (act_q & ~(5'd1 << idx_q));
    lost     = watch & ~bus.pg;
    lost_any = |lost;
    lost_idx = '0;
    for (int j = 4; j >= 0; j--) begin
      if (lost[j]) lost_idx = 3'(j);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    act_d     = act_q;
    rail_d    = rail_q;
    timer_clr = 1'b0;
`ifdef SEQ_AUTO_RETRY_EN
    retries_d = retries_q;
`endif
    unique case (state_q)
      StIdle: begin
        act_d = '0;
        if (bus.start && !bus.stop) begin
          state_d = StUp;
          idx_d   = '0;
          act_d   = 5'd1;
        end
      end
      StUp, StDwell, StOn: begin
        if (lost_any) begin
          state_d = StFault;
          act_d   = '0;
          rail_d  = lost_idx;
        end else if (bus.stop) begin
          state_d = StDown;
          act_d   = act_q & ~(5'd1 << idx_q);
        end else if (state_q == StUp) begin
          if (pg_cur) begin
            state_d = (idx_q == 3'd4) ? StOn : StDwell;
          end else if (at_timeout) begin
            state_d = StFault;
            act_d   = '0;
            rail_d  = idx_q;
          end
        end else if (state_q == StDwell && at_step) begin
          state_d = StUp;
          idx_d   = idx_q + 3'd1;
          act_d   = act_q | (5'd1 << (idx_q + 3'd1));
        end
      end
      StDown: begin
        if (at_step) begin
          timer_clr = 1'b1;
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
            act_d = act_q & ~(5'd1 << (idx_q - 3'd1));
          end else begin
            state_d = StIdle;
            act_d   = '0;
          end
        end
      end
      StFault: begin
        act_d = '0;
        if (bus.clr_fault) begin
          state_d = StIdle;
`ifdef SEQ_AUTO_RETRY_EN
          retries_d = '0;
        end else if (at_retry && (32'(retries_q) < MAX_RETRIES)) begin
          retries_d = retries_q + 2'd1;
          state_d   = StUp;
          idx_d     = '0;
          act_d     = 5'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        act_d   = '0;
      end
    endcase
`ifdef SEQ_AUTO_RETRY_EN
    if (state_d == StOn) retries_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      timer_q <= '0;
      act_q   <= '0;
      rail_q  <= '0;
      good_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      rail_q  <= rail_d;
      good_q  <= (state_d == StOn);
      fault_q <= (state_d == StFault);
      if (timer_clr || (state_d != state_q)) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + 24'd1;
      end
    end
  end

`ifdef SEQ_AUTO_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) retries_q <= '0;
    else     retries_q <= retries_d;
  end
`endif

  assign bus.act_ctl    = act_q;
  assign bus.state      = state_q;
  assign bus.all_good   = good_q;
  assign bus.fault      = fault_q;
  assign bus.fault_rail = rail_q;

endmodule

// File: tb/tb_psu_rail_sequencer.sv
// Directed bench for psu_rail_sequencer: vector table plus multi-cycle sequences with a
// power-good model where each rail reports good three cycles after its enable.
module tb_psu_rail_sequencer;
  localparam int unsigned SD = 4;
  localparam int unsigned PT = 16;
  localparam int unsigned RD = 8;
  localparam int unsigned MR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psu_rail_sequencer_if bus();

  psu_rail_sequencer #(
    .STEP_DELAY (SD),
    .PG_TIMEOUT (PT),
    .RETRY_DELAY(RD),
    .MAX_RETRIES(MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       clr;
    logic [4:0] pg;
    logic [4:0] act;
    logic [2:0] st;
    logic       good;
    logic       flt;
    logic [2:0] rail;
  } vec_t;

  int ncmp = 0;
  int nfail = 0;
  logic       pg_auto;
  logic [4:0] pg_mask;
  int         cnt[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock; the power-good model follows the enables seen after the edge.
  task automatic tick();
    logic [4:0] p;
    @(posedge clk);
    #1;
    p = '0;
    for (int i = 0; i < 5; i++) begin
      if (bus.act_ctl[i]) begin
        if (cnt[i] < 1000) cnt[i]++;
      end else begin
        cnt[i] = 0;
      end
      p[i] = (cnt[i] >= 3) && pg_mask[i];
    end
    if (pg_auto) bus.pg = p;
  endtask

  task automatic run_until_on();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 100 && bus.state != 3'd3; c++) tick();
    chk("reach_on_state", 32'(bus.state), 3);
    chk("reach_on_good", 32'(bus.all_good), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  vec_t       tbl[27];
  logic [4:0] seq[5];
  logic [4:0] dn[4];
  logic [4:0] prev;
  int         k, cyc, last, n;

  initial begin
    seq = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31};
    dn  = '{5'd7, 5'd3, 5'd1, 5'd0};
    //            start stop clr pg      act     st    good flt rail
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'h00, 5'd0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 5'h00, 5'd0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd1, 3'd1, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd3, 3'd1, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'h01, 5'd1, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'h01, 5'd1, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'h01, 5'd1, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd1, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd0, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd0, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd0, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd0, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'd0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'd1, 3'd1, 1'b0, 1'b0, 3'd0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd1, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 5'h01, 5'd3, 3'd1, 1'b0, 1'b0, 3'd0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 5'h03, 5'd3, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 5'h02, 5'd0, 3'd5, 1'b0, 1'b1, 3'd0};
    tbl[25] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'd0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'd0, 3'd0, 1'b0, 1'b0, 3'd0};

    pg_auto = 1'b0;
    pg_mask = 5'h1f;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clr_fault = 1'b0;
    bus.pg = '0;
    tick();
    tick();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_act", 32'(bus.act_ctl), 0);
    chk("rst_good", 32'(bus.all_good), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_rail", 32'(bus.fault_rail), 0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      bus.start = tbl[i].start;
      bus.stop = tbl[i].stop;
      bus.clr_fault = tbl[i].clr;
      bus.pg = tbl[i].pg;
      tick();
      chk($sformatf("vec%0d_act", i), 32'(bus.act_ctl), 32'(tbl[i].act));
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_good", i), 32'(bus.all_good), 32'(tbl[i].good));
      chk($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'(tbl[i].flt));
      chk($sformatf("vec%0d_rail", i), 32'(bus.fault_rail), 32'(tbl[i].rail));
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clr_fault = 1'b0;

    // Nominal bring-up: enables step every 3 (pg) + 4 (dwell) cycles.
    pg_auto = 1'b1;
    bus.pg = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("pwr_first_act", 32'(bus.act_ctl), 1);
    chk("pwr_first_state", 32'(bus.state), 1);
    prev = bus.act_ctl;
    k = 1;
    cyc = 0;
    last = 0;
    for (int c = 0; c < 100 && bus.state != 3'd3; c++) begin
      tick();
      cyc++;
      if (bus.act_ctl != prev) begin
        chk("pwr_step", 32'(bus.act_ctl), (k < 5) ? 32'(seq[k]) : 32'd0);
        chk("pwr_gap", 32'(cyc - last), 7);
        last = cyc;
        prev = bus.act_ctl;
        k++;
      end
    end
    chk("pwr_steps", 32'(k), 5);
    chk("pwr_on_delay", 32'(cyc - last), 3);
    chk("pwr_on_act", 32'(bus.act_ctl), 31);
    chk("pwr_all_good", 32'(bus.all_good), 1);

    // Reverse shutdown; start held during DOWN must not matter.
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.start = 1'b1;
    chk("dn_entry_act", 32'(bus.act_ctl), 15);
    chk("dn_entry_state", 32'(bus.state), 4);
    chk("dn_entry_good", 32'(bus.all_good), 0);
    prev = 5'd15;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 3; h++) begin
        tick();
        chk("dn_hold", 32'(bus.act_ctl), 32'(prev));
      end
      tick();
      chk("dn_step", 32'(bus.act_ctl), 32'(dn[s]));
      prev = dn[s];
    end
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("dn_tail_state", 32'(bus.state), 4);
    end
    tick();
    chk("dn_idle", 32'(bus.state), 0);
    bus.start = 1'b0;
    tick();
    chk("dn_idle_stays", 32'(bus.state), 0);

    // Brown-out: two rails drop together, lowest index is reported.
    run_until_on();
    pg_auto = 1'b0;
    bus.pg = 5'b10101;
    tick();
    chk("bo_state", 32'(bus.state), 5);
    chk("bo_act", 32'(bus.act_ctl), 0);
    chk("bo_fault", 32'(bus.fault), 1);
    chk("bo_rail", 32'(bus.fault_rail), 1);
    chk("bo_good", 32'(bus.all_good), 0);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    chk("bo_clear", 32'(bus.state), 0);
    chk("bo_rail_hold", 32'(bus.fault_rail), 1);

    // Timeout on rail 2.
    bus.pg = '0;
    pg_auto = 1'b1;
    pg_mask = 5'b11011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 60 && bus.act_ctl != 5'd7; c++) tick();
    chk("to_act7", 32'(bus.act_ctl), 7);
    n = 0;
    for (int c = 0; c < 40 && bus.state != 3'd5; c++) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 16);
    chk("to_act", 32'(bus.act_ctl), 0);
    chk("to_rail", 32'(bus.fault_rail), 2);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    chk("to_clear", 32'(bus.state), 0);

    // Reset mid bring-up drops every enable.
    pg_mask = 5'h1f;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 40 && bus.act_ctl != 5'd3; c++) tick();
    chk("mr_act3", 32'(bus.act_ctl), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_act", 32'(bus.act_ctl), 0);
    chk("mr_state", 32'(bus.state), 0);

    // Rail 0 never good: timeout, optional retries, then the fault latches.
    pg_mask = 5'b11110;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    for (int c = 0; c < 40 && bus.state != 3'd5; c++) begin
      tick();
      n++;
    end
    chk("rt_first_fault", 32'(n), 17);
    chk("rt_rail", 32'(bus.fault_rail), 0);
`ifdef SEQ_AUTO_RETRY_EN
    for (int r = 0; r < 2; r++) begin
      n = 0;
      for (int c = 0; c < 30 && bus.state != 3'd1; c++) begin
        tick();
        n++;
      end
      chk("rt_restart_gap", 32'(n), 8);
      chk("rt_restart_act", 32'(bus.act_ctl), 1);
      n = 0;
      for (int c = 0; c < 40 && bus.state != 3'd5; c++) begin
        tick();
        n++;
      end
      chk("rt_refault_gap", 32'(n), 16);
    end
`endif
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.state == 3'd5 && bus.act_ctl == 5'd0) n++;
    end
    chk("rt_latched", 32'(n), 40);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    chk("rt_clear", 32'(bus.state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
